block_assembler: RTL and testbench
==================================

BLOCK_ASSEMBLER -- requirements
Module: block_assembler

Interface
REQ-001 Parameter Data_Depth, default 8, pixel width in bits.
REQ-002 Parameter Max_Block_Dim, default 72, maximum block side M.
REQ-003 Parameter Max_Image_Width, default 720, maximum image width N in pixels.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 cfg_valid  input  1  one-cycle strobe latching cfg_M, cfg_N, cfg_H; honoured only in IDLE.
REQ-007 cfg_M  input  8  block side M; cfg_N input 10, image width; cfg_H input 10, image height.
REQ-008 Pixel_in  input  Data_Depth  watermarked pixel, block order, row-major within a block.
REQ-009 pixel_valid  input  1  Pixel_in is valid this cycle; it is the new_pixel pulse of the watermarking core.
REQ-010 in_ready  output  1  block accepts Pixel_in this cycle.
REQ-011 Pixel_out  output  Data_Depth  raster-order pixel; out_valid output 1; out_ready input 1.
REQ-012 line_end  output  1  high with the last out_valid pixel of each image row.
REQ-013 frame_done  output  1  one-cycle pulse after the last frame pixel handshakes.
REQ-014 cfg_err  output  1  sticky flag for illegal configuration; cleared by the next legal cfg_valid or by reset.

Function
REQ-015 States: IDLE, FILL, DRAIN; IDLE->FILL on a legal cfg_valid.
REQ-016 A configuration is legal only when 2<=M<=Max_Block_Dim, N<=Max_Image_Width, N%M==0 and H%M==0, with N, H >= M; an illegal one sets cfg_err and stays in IDLE.
REQ-017 Stripe = M rows x N columns = N/M blocks of M*M pixels.
REQ-018 FILL writes the pixel at in-block row r, column c of block b to buffer address r*N + b*M + c, using counters and no dividers.
REQ-019 A pixel is accepted only when pixel_valid && in_ready; in FILL, in_ready=1.
REQ-020 After the M*N-th stripe pixel is accepted, FILL->DRAIN.
REQ-021 DRAIN reads addresses 0..M*N-1 linearly through a synchronous-read buffer with 1-cycle read latency.
REQ-022 Pixel_out is registered; first out_valid occurs 2 cycles after DRAIN is entered.
REQ-023 While out_valid && !out_ready, Pixel_out, out_valid and line_end hold stable.
REQ-024 line_end asserts on output column N-1 of each row.
REQ-025 When the stripe drains and more stripes remain (H/M total), DRAIN->FILL; after the last stripe, DRAIN->IDLE and frame_done pulses.
REQ-026 pixel_valid while in_ready=0 is dropped and sets sticky overflow bit ovf (internal, observable via hierarchy).
REQ-027 cfg_valid outside IDLE is ignored.

Reset
REQ-028 On rst=0 at posedge: state IDLE, all counters 0, in_ready=0, out_valid=0, Pixel_out=0, line_end=0, frame_done=0, cfg_err=0, ovf=0.
REQ-029 Reset mid-FILL or mid-DRAIN abandons the frame; buffer contents are don't-care, and a new cfg_valid is required.

Configuration
REQ-030 Macro BLOCK_ASSEMBLER_PINGPONG_EN selects the buffering mode.
REQ-031 Defined: two stripe buffers; FILL of stripe k+1 overlaps DRAIN of stripe k, and in_ready stays 1 except when both buffers hold undrained data.
REQ-032 Undefined: one buffer; in_ready=0 throughout DRAIN.
REQ-033 In both modes, output order and values are identical.

Structure
REQ-034 A shared package block_pkg holds the state enum, the legality-check function, and the derived address widths $clog2(Max_Block_Dim*Max_Image_Width).
REQ-035 One sub-module, stripe_ram: single write port, single synchronous read port, instantiated once or twice depending on BLOCK_ASSEMBLER_PINGPONG_EN.

Verification
REQ-036 M=2, N=4, H=2, blocks [1,2,3,4],[5,6,7,8] -> Pixel_out 1,2,5,6,3,4,7,8; line_end on 6 and 8; frame_done once.
REQ-037 M=2, N=4, H=4, two stripes -> 16 raster pixels in order, line_end 4 times; without the macro, in_ready=0 during each DRAIN.
REQ-038 out_ready toggled 1,0,0,1 during DRAIN -> each pixel held stable while stalled, with no loss or duplication.
REQ-039 cfg_M=3, cfg_N=4 -> cfg_err=1 and state stays IDLE; then legal cfg -> cfg_err=0 and FILL.
REQ-040 rst=0 asserted mid-DRAIN -> all outputs at reset values next cycle; a new frame afterwards is correct.
REQ-041 With the macro, M=2, N=4, H=4 and continuous pixel_valid -> no drops (ovf=0) and output identical to REQ-037.

Source files
------------

// File: rtl/block_pkg.sv
// block_pkg: state enum, configuration legality check and buffer
// address sizing shared by the block assembler files.
package block_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  function automatic int addr_w(input int max_m, input int max_n);
    return $clog2(max_m * max_n);
  endfunction

  function automatic logic legal_cfg(
    input logic [7:0] m,
    input logic [9:0] n,
    input logic [9:0] h,
    input int         max_m,
    input int         max_n
  );
    int mi, ni, hi;
    mi = int'(m);
    ni = int'(n);
    hi = int'(h);
    if (mi < 2 || mi > max_m) return 1'b0;
    if (ni > max_n || ni < mi || hi < mi) return 1'b0;
    return (ni % mi == 0) && (hi % mi == 0);
  endfunction

endpackage

// File: rtl/stripe_ram.sv
// stripe_ram: one stripe of pixels, single write port and a
// synchronous read port whose output holds while re is low.
module stripe_ram #(
  parameter int W     = 8,
  parameter int AW    = 16,
  parameter int DEPTH = 51840
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/block_assembler.sv
// block_assembler: reorders MxM block-ordered pixels into raster rows.
// Define BLOCK_ASSEMBLER_PINGPONG_EN for two overlapping stripe buffers.
module block_assembler
  import block_pkg::*;
#(
  parameter int Data_Depth      = 8,
  parameter int Max_Block_Dim   = 72,
  parameter int Max_Image_Width = 720
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_M,
  input  logic [9:0]            cfg_N,
  input  logic [9:0]            cfg_H,
  input  logic [Data_Depth-1:0] Pixel_in,
  input  logic                  pixel_valid,
  output logic                  in_ready,
  output logic [Data_Depth-1:0] Pixel_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  line_end,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam int AW    = addr_w(Max_Block_Dim, Max_Image_Width);
  localparam int DEPTH = Max_Block_Dim * Max_Image_Width;
`ifdef BLOCK_ASSEMBLER_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  state_t          state;
  logic [7:0]      m;
  logic [9:0]      n, h;
  logic            ovf;

  logic [7:0]      wc, wr;
  logic [AW-1:0]   row_base, blk_base;
  logic [9:0]      wr_rows;
  logic            wr_sel;

  logic [AW-1:0]   rd_addr;
  logic [9:0]      rd_col;
  logic [7:0]      rd_row;
  logic [9:0]      rd_rows;
  logic            issued_all, rd_sel;
  logic            p1_valid, p1_le, p1_last, out_last;
  logic [1:0]      full, full_nx;
  logic            rd_sel_nx;

  logic [Data_Depth-1:0] q [2];

  logic            wr_fire, row_end_w, blk_end, stripe_end_w;
  logic            adv, rd_issue, rd_line, rd_stripe_last;
  logic            hs, stripe_done, frame_last;
  logic [AW-1:0]   wr_addr;

  assign in_ready = (state != IDLE) && !full[wr_sel] && (wr_rows != h);
  assign wr_fire  = pixel_valid && in_ready;
  assign wr_addr  = row_base + blk_base + AW'(wc);
  assign row_end_w    = wc == m - 8'd1;
  assign blk_end      = row_end_w && (wr == m - 8'd1);
  assign stripe_end_w = blk_end && (blk_base + AW'(m) == AW'(n));

  // Two-stage read pipeline (RAM register, output register) stalls as a unit.
  assign hs       = out_valid && out_ready;
  assign adv      = !out_valid || out_ready;
  assign rd_issue = adv && full[rd_sel] && !issued_all;
  assign rd_line  = rd_col == n - 10'd1;
  assign rd_stripe_last = rd_line && (rd_row == m - 8'd1);
  assign stripe_done    = hs && out_last;
  assign frame_last = stripe_done &&
                      ({1'b0, rd_rows} + 11'(m) == {1'b0, h});

  always_comb begin
    full_nx   = full;
    rd_sel_nx = rd_sel;
    if (wr_fire && stripe_end_w) full_nx[wr_sel] = 1'b1;
    if (stripe_done) full_nx[rd_sel] = 1'b0;
    if (stripe_done && NBUF == 2) rd_sel_nx = !rd_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      m          <= '0;
      n          <= '0;
      h          <= '0;
      cfg_err    <= 1'b0;
      ovf        <= 1'b0;
      wc         <= '0;
      wr         <= '0;
      row_base   <= '0;
      blk_base   <= '0;
      wr_rows    <= '0;
      wr_sel     <= 1'b0;
      rd_addr    <= '0;
      rd_col     <= '0;
      rd_row     <= '0;
      rd_rows    <= '0;
      issued_all <= 1'b0;
      rd_sel     <= 1'b0;
      p1_valid   <= 1'b0;
      p1_le      <= 1'b0;
      p1_last    <= 1'b0;
      out_last   <= 1'b0;
      full       <= '0;
      Pixel_out  <= '0;
      out_valid  <= 1'b0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pixel_valid && !in_ready) ovf <= 1'b1;
      if (state == IDLE) begin
        if (cfg_valid) begin
          if (legal_cfg(cfg_M, cfg_N, cfg_H,
                        Max_Block_Dim, Max_Image_Width)) begin
            m          <= cfg_M;
            n          <= cfg_N;
            h          <= cfg_H;
            cfg_err    <= 1'b0;
            state      <= FILL;
            wc         <= '0;
            wr         <= '0;
            row_base   <= '0;
            blk_base   <= '0;
            wr_rows    <= '0;
            wr_sel     <= 1'b0;
            rd_addr    <= '0;
            rd_col     <= '0;
            rd_row     <= '0;
            rd_rows    <= '0;
            issued_all <= 1'b0;
            rd_sel     <= 1'b0;
            full       <= '0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else begin
        full   <= full_nx;
        rd_sel <= rd_sel_nx;
        state  <= frame_last ? IDLE :
                  (full_nx[rd_sel_nx] ? DRAIN : FILL);
        if (frame_last) frame_done <= 1'b1;

        if (wr_fire) begin
          if (!row_end_w) begin
            wc <= wc + 8'd1;
          end else begin
            wc <= '0;
            if (!blk_end) begin
              wr       <= wr + 8'd1;
              row_base <= row_base + AW'(n);
            end else begin
              wr       <= '0;
              row_base <= '0;
              if (!stripe_end_w) begin
                blk_base <= blk_base + AW'(m);
              end else begin
                blk_base <= '0;
                wr_rows  <= wr_rows + 10'(m);
                if (NBUF == 2) wr_sel <= !wr_sel;
              end
            end
          end
        end

        if (rd_issue) begin
          rd_addr <= rd_addr + AW'(1);
          rd_col  <= rd_line ? '0 : rd_col + 10'd1;
          if (rd_line) rd_row <= rd_row + 8'd1;
          if (rd_stripe_last) begin
            issued_all <= 1'b1;
            rd_addr    <= '0;
            rd_row     <= '0;
          end
        end
        if (stripe_done) begin
          issued_all <= 1'b0;
          rd_rows    <= rd_rows + 10'(m);
        end

        if (adv) begin
          p1_valid  <= rd_issue;
          p1_le     <= rd_issue && rd_line;
          p1_last   <= rd_issue && rd_stripe_last;
          out_valid <= p1_valid;
          line_end  <= p1_valid && p1_le;
          out_last  <= p1_valid && p1_last;
          if (p1_valid) Pixel_out <= q[rd_sel];
        end
      end
    end
  end

  stripe_ram #(.W(Data_Depth), .AW(AW), .DEPTH(DEPTH)) u_ram0 (
    .clk   (clk),
    .we    (wr_fire && !wr_sel),
    .waddr (wr_addr),
    .wdata (Pixel_in),
    .re    (adv),
    .raddr (rd_addr),
    .rdata (q[0])
  );

`ifdef BLOCK_ASSEMBLER_PINGPONG_EN
  stripe_ram #(.W(Data_Depth), .AW(AW), .DEPTH(DEPTH)) u_ram1 (
    .clk   (clk),
    .we    (wr_fire && wr_sel),
    .waddr (wr_addr),
    .wdata (Pixel_in),
    .re    (adv),
    .raddr (rd_addr),
    .rdata (q[1])
  );
`else
  assign q[1] = '0;
`endif

endmodule

// File: tb/tb_block_assembler.sv
// tb_block_assembler: raster-image reference model, legality table and
// hand sequences for stalls and mid-frame reset.
module tb_block_assembler;
  import block_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_M;
  logic [9:0] cfg_N, cfg_H;
  logic [7:0] Pixel_in;
  logic       pixel_valid;
  logic       in_ready;
  logic [7:0] Pixel_out;
  logic       out_valid;
  logic       out_ready;
  logic       line_end;
  logic       frame_done;
  logic       cfg_err;

  always #5 clk = ~clk;

  block_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_M       (cfg_M),
    .cfg_N       (cfg_N),
    .cfg_H       (cfg_H),
    .Pixel_in    (Pixel_in),
    .pixel_valid (pixel_valid),
    .in_ready    (in_ready),
    .Pixel_out   (Pixel_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .line_end    (line_end),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  typedef struct {
    int m;
    int n;
    int h;
    bit err;
  } cfg_vec_t;

  cfg_vec_t   cfg_tab[10];
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  bit         exp_le[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    cfg_valid = 1'b0;
    pixel_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " Pixel_out"}, 32'(Pixel_out), 32'd0);
    check({tag, " line_end"}, 32'(line_end), 32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, " ovf"}, 32'(dut.ovf), 32'd0);
    check({tag, " state"}, 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
  endtask

  task automatic apply_cfg(input int m, input int n, input int h);
    cfg_M = 8'(m);
    cfg_N = 10'(n);
    cfg_H = 10'(h);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Reference: an NxH raster image, fed stripe by stripe in block order.
  task automatic make_frame(input int m, input int n, input int h,
                            input bit seq);
    logic [7:0] img[];
    img = new[n * h];
    foreach (img[i]) img[i] = seq ? 8'(i + 1) : 8'($urandom);
    in_q.delete();
    exp_q.delete();
    exp_le.delete();
    for (int s = 0; s < h / m; s++)
      for (int b = 0; b < n / m; b++)
        for (int r = 0; r < m; r++)
          for (int c = 0; c < m; c++)
            in_q.push_back(img[(s * m + r) * n + b * m + c]);
    foreach (img[i]) begin
      exp_q.push_back(img[i]);
      exp_le.push_back(i % n == n - 1);
    end
  endtask

  task automatic run_frame(input int m, input int n, input int h,
                           input int rdy_pct, input int vld_pct,
                           input string tag);
    int sent, got, fd, cyc;
    bit stall;
    logic [7:0] px_prev;
    logic le_prev;
    sent = 0;
    got = 0;
    fd = 0;
    cyc = 0;
    stall = 1'b0;
    px_prev = '0;
    le_prev = 1'b0;
    apply_cfg(m, n, h);
    check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, " state_fill"}, 32'(dut.state), 32'(FILL));
    while ((got < exp_q.size() || fd == 0) && cyc < 20000) begin
      if (stall)
        check({tag, " hold"}, 32'({out_valid, line_end, Pixel_out}),
              32'({1'b1, le_prev, px_prev}));
      if (frame_done) begin
        fd++;
        check({tag, " done_after_last"}, 32'(got), 32'(exp_q.size()));
      end
`ifndef BLOCK_ASSEMBLER_PINGPONG_EN
      if (dut.state == DRAIN)
        check({tag, " in_ready_in_drain"}, 32'(in_ready), 32'd0);
`endif
      if (rdy_pct < 0)
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else
        out_ready = int'($urandom_range(99)) < rdy_pct;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) begin
          check({tag, " pixel"}, 32'(Pixel_out), 32'(exp_q[got]));
          check({tag, " line_end"}, 32'(line_end), 32'(exp_le[got]));
        end else begin
          checks++;
          errors++;
          $display("FAIL %s extra_pixel: got %0h expected none", tag,
                   Pixel_out);
        end
        got++;
      end
      if (sent < in_q.size() && in_ready &&
          int'($urandom_range(99)) < vld_pct) begin
        pixel_valid = 1'b1;
        Pixel_in = in_q[sent];
        sent++;
      end else begin
        pixel_valid = 1'b0;
        Pixel_in = 8'($urandom);
      end
      stall = out_valid && !out_ready;
      px_prev = Pixel_out;
      le_prev = line_end;
      @(negedge clk);
      cyc++;
    end
    pixel_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      if (frame_done) fd++;
      @(negedge clk);
    end
    check({tag, " all_pixels"}, 32'(got), 32'(exp_q.size()));
    check({tag, " all_sent"}, 32'(sent), 32'(in_q.size()));
    check({tag, " frame_done_once"}, 32'(fd), 32'd1);
    check({tag, " state_idle"}, 32'(dut.state), 32'(IDLE));
    check({tag, " ovf"}, 32'(dut.ovf), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int m, n, h;
    cfg_tab[0] = '{3, 4, 4, 1'b1};
    cfg_tab[1] = '{1, 4, 4, 1'b1};
    cfg_tab[2] = '{2, 4, 3, 1'b1};
    cfg_tab[3] = '{4, 2, 4, 1'b1};
    cfg_tab[4] = '{2, 722, 4, 1'b1};
    cfg_tab[5] = '{74, 148, 148, 1'b1};
    cfg_tab[6] = '{2, 4, 2, 1'b0};
    cfg_tab[7] = '{0, 4, 4, 1'b1};
    cfg_tab[8] = '{72, 720, 72, 1'b0};
    cfg_tab[9] = '{2, 2, 2, 1'b0};

    cfg_valid = 1'b0;
    cfg_M = '0;
    cfg_N = '0;
    cfg_H = '0;
    Pixel_in = '0;
    pixel_valid = 1'b0;
    out_ready = 1'b0;
    do_reset("reset");

    pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    check("ovf_set", 32'(dut.ovf), 32'd1);
    check("ovf_idle", 32'(dut.state), 32'(IDLE));
    do_reset("ovf_clear");

    foreach (cfg_tab[i]) begin
      apply_cfg(cfg_tab[i].m, cfg_tab[i].n, cfg_tab[i].h);
      check($sformatf("cfg%0d err", i), 32'(cfg_err), 32'(cfg_tab[i].err));
      check($sformatf("cfg%0d state", i), 32'(dut.state),
            cfg_tab[i].err ? 32'(IDLE) : 32'(FILL));
      check($sformatf("cfg%0d in_ready", i), 32'(in_ready),
            32'(!cfg_tab[i].err));
      if (!cfg_tab[i].err) begin
        apply_cfg(3, 4, 4);
        check($sformatf("cfg%0d ignore_err", i), 32'(cfg_err), 32'd0);
        check($sformatf("cfg%0d ignore_state", i), 32'(dut.state),
              32'(FILL));
        do_reset($sformatf("cfg%0d reset", i));
      end
    end

    in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    exp_q = '{8'd1, 8'd2, 8'd5, 8'd6, 8'd3, 8'd4, 8'd7, 8'd8};
    exp_le = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_frame(2, 4, 2, 100, 100, "m2n4h2");

    make_frame(2, 4, 4, 1'b1);
    run_frame(2, 4, 4, 100, 100, "m2n4h4");

    make_frame(2, 4, 4, 1'b0);
    run_frame(2, 4, 4, -1, 100, "stall1001");

    make_frame(2, 4, 2, 1'b1);
    in_q = make_q_copy(in_q);
    apply_cfg(2, 4, 2);
    sent = 0;
    for (int i = 0; i < 200 && !out_valid; i++) begin
      if (sent < in_q.size() && in_ready) begin
        pixel_valid = 1'b1;
        Pixel_in = in_q[sent];
        sent++;
      end else begin
        pixel_valid = 1'b0;
      end
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    check("mid_drain out_valid", 32'(out_valid), 32'd1);
    do_reset("mid_drain_reset");

    make_frame(2, 4, 4, 1'b0);
    run_frame(2, 4, 4, 70, 80, "after_reset");

    for (int k = 0; k < 6; k++) begin
      m = 2 + int'($urandom_range(2));
      n = m * (1 + int'($urandom_range(5)));
      h = m * (1 + int'($urandom_range(3)));
      make_frame(m, n, h, 1'b0);
      run_frame(m, n, h, 30 + int'($urandom_range(70)),
                30 + int'($urandom_range(70)), $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic void noop();
  endfunction

  function automatic logic [7:0] q_at(input int i);
    return in_q[i];
  endfunction

  typedef logic [7:0] byte_q_t[$];

  function automatic byte_q_t make_q_copy(input byte_q_t src);
    byte_q_t dst;
    foreach (src[i]) dst.push_back(src[i]);
    return dst;
  endfunction

endmodule
